// File: rtl/rx_frame_dispatch.sv
// Per-frame receive dispatcher: filters on destination MAC and EtherType, steers
// each frame to the IPv4 or ARP sink. Optional macro RX_DISPATCH_PROMISC_EN adds a promisc bypass input.
module rx_frame_dispatch #(
  parameter int MAX_BYTES = 1500,
  parameter int CNT_W     = 16
) (
  input  logic             rx_clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [47:0]      local_mac,
`ifdef RX_DISPATCH_PROMISC_EN
  input  logic             promisc,
`endif
  input  logic             in_start,
  input  logic             in_en,
  input  logic [7:0]       in_dat,
  input  logic             in_end,
  input  logic [47:0]      in_des_mac,
  input  logic [15:0]      in_prot_type,
  input  logic             ip_rdy,
  input  logic             arp_rdy,
  output logic             ip_start,
  output logic             ip_en,
  output logic             ip_end,
  output logic [7:0]       ip_dat,
  output logic             arp_start,
  output logic             arp_en,
  output logic             arp_end,
  output logic [7:0]       arp_dat,
  output logic             frm_err,
  output logic [CNT_W-1:0] cnt_ip,
  output logic [CNT_W-1:0] cnt_arp,
  output logic [CNT_W-1:0] cnt_drop_mac,
  output logic [CNT_W-1:0] cnt_drop_type,
  output logic [CNT_W-1:0] cnt_drop_busy
);

  typedef enum logic [1:0] {IDLE, FWD_IP, FWD_ARP, DROP} state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  state_t      state, state_nxt;
  logic [10:0] byte_cnt, byte_cnt_nxt;
  logic        trunc, trunc_nxt;
  logic        ip_start_nxt, ip_en_nxt, ip_end_nxt;
  logic        arp_start_nxt, arp_en_nxt, arp_end_nxt;
  logic [7:0]  ip_dat_nxt, arp_dat_nxt;
  logic        frm_err_nxt;
  logic        inc_ip, inc_arp, inc_mac, inc_type, inc_busy;
  logic        mac_ok, type_ip, type_arp;

`ifdef RX_DISPATCH_PROMISC_EN
  assign mac_ok = promisc || (in_des_mac == local_mac) || (in_des_mac == 48'hFFFF_FFFF_FFFF);
`else
  assign mac_ok = (in_des_mac == local_mac) || (in_des_mac == 48'hFFFF_FFFF_FFFF);
`endif
  assign type_ip  = (in_prot_type == 16'h0800);
  assign type_arp = (in_prot_type == 16'h0806);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    trunc_nxt     = trunc;
    ip_start_nxt  = 1'b0;
    ip_en_nxt     = 1'b0;
    ip_end_nxt    = 1'b0;
    ip_dat_nxt    = 8'h00;
    arp_start_nxt = 1'b0;
    arp_en_nxt    = 1'b0;
    arp_end_nxt   = 1'b0;
    arp_dat_nxt   = 8'h00;
    frm_err_nxt   = 1'b0;
    inc_ip        = 1'b0;
    inc_arp       = 1'b0;
    inc_mac       = 1'b0;
    inc_type      = 1'b0;
    inc_busy      = 1'b0;

    if (state == FWD_IP || state == FWD_ARP) begin
      if (in_en) begin
        if (byte_cnt < MAX_CNT) begin
          byte_cnt_nxt = byte_cnt + 11'd1;
          if (state == FWD_IP) begin
            ip_en_nxt  = 1'b1;
            ip_dat_nxt = in_dat;
          end else begin
            arp_en_nxt  = 1'b1;
            arp_dat_nxt = in_dat;
          end
        end else begin
          trunc_nxt = 1'b1;
        end
      end
      // A new start without an end closes the old frame as aborted.
      if (in_end || in_start) begin
        if (state == FWD_IP) ip_end_nxt = 1'b1;
        else                 arp_end_nxt = 1'b1;
        frm_err_nxt  = trunc_nxt || !in_end;
        state_nxt    = IDLE;
        byte_cnt_nxt = 11'd0;
        trunc_nxt    = 1'b0;
      end
    end else if (state == DROP && in_end) begin
      state_nxt = IDLE;
    end

    if (in_start) begin
      byte_cnt_nxt = 11'd0;
      trunc_nxt    = 1'b0;
      state_nxt    = DROP;
      if (cfg_en) begin
        if (!mac_ok) begin
          inc_mac = 1'b1;
        end else if (!type_ip && !type_arp) begin
          inc_type = 1'b1;
        end else if (type_ip) begin
          if (ip_rdy) begin
            state_nxt    = FWD_IP;
            ip_start_nxt = 1'b1;
            inc_ip       = 1'b1;
          end else begin
            inc_busy = 1'b1;
          end
        end else begin
          if (arp_rdy) begin
            state_nxt     = FWD_ARP;
            arp_start_nxt = 1'b1;
            inc_arp       = 1'b1;
          end else begin
            inc_busy = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_cnt      <= 11'd0;
      trunc         <= 1'b0;
      ip_start      <= 1'b0;
      ip_en         <= 1'b0;
      ip_end        <= 1'b0;
      ip_dat        <= 8'h00;
      arp_start     <= 1'b0;
      arp_en        <= 1'b0;
      arp_end       <= 1'b0;
      arp_dat       <= 8'h00;
      frm_err       <= 1'b0;
      cnt_ip        <= '0;
      cnt_arp       <= '0;
      cnt_drop_mac  <= '0;
      cnt_drop_type <= '0;
      cnt_drop_busy <= '0;
    end else begin
      state         <= state_nxt;
      byte_cnt      <= byte_cnt_nxt;
      trunc         <= trunc_nxt;
      ip_start      <= ip_start_nxt;
      ip_en         <= ip_en_nxt;
      ip_end        <= ip_end_nxt;
      ip_dat        <= ip_dat_nxt;
      arp_start     <= arp_start_nxt;
      arp_en        <= arp_en_nxt;
      arp_end       <= arp_end_nxt;
      arp_dat       <= arp_dat_nxt;
      frm_err       <= frm_err_nxt;
      cnt_ip        <= sat_inc(cnt_ip, inc_ip);
      cnt_arp       <= sat_inc(cnt_arp, inc_arp);
      cnt_drop_mac  <= sat_inc(cnt_drop_mac, inc_mac);
      cnt_drop_type <= sat_inc(cnt_drop_type, inc_type);
      cnt_drop_busy <= sat_inc(cnt_drop_busy, inc_busy);
    end
  end

endmodule
